// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and WB->ID bypass; 1-cycle latency.
// Backpressure: stall_d (combinational) holds PC and IF/ID for one cycle; stall or flush injects a bubble.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_d,
   input  logic [8:0]        ctrl_d,
   input  logic [5:0]        op_d,
   input  logic [5:0]        func_d,
   input  logic [DATA_W-1:0] rdata1_d,
   input  logic [DATA_W-1:0] rdata2_d,
   input  logic [DATA_W-1:0] imm_d,
   input  logic [4:0]        shamt_d,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic [DATA_W-1:0] pc4_d,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush_e,
   output logic              stall_d,
   output logic              valid_e,
   output logic [8:0]        ctrl_e,
   output logic [5:0]        op_e,
   output logic [5:0]        func_e,
   output logic [DATA_W-1:0] rdata1_e,
   output logic [DATA_W-1:0] rdata2_e,
   output logic [DATA_W-1:0] imm_e,
   output logic [4:0]        shamt_e,
   output logic [REG_AW-1:0] rs_e,
   output logic [REG_AW-1:0] rt_e,
   output logic [REG_AW-1:0] rd_e,
   output logic [DATA_W-1:0] pc4_e
);

   // ctrl bit order: {regWrite,memToReg,memWrite,memRead,branch,shiftD,aluSrc,regDst,isJAL}
   localparam int MEMREAD_BIT = 5;

   typedef struct packed {
      logic              valid;
      logic [8:0]        ctrl;
      logic [5:0]        op;
      logic [5:0]        func;
      logic [DATA_W-1:0] rdata1;
      logic [DATA_W-1:0] rdata2;
      logic [DATA_W-1:0] imm;
      logic [4:0]        shamt;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] pc4;
   } ex_t;

   ex_t  ex_q, ex_d;
   logic byp1, byp2, stall, bubble;

   always_comb begin
      ex_d  = '0;
      byp1  = wb_we && (wb_addr != '0) && (wb_addr == rs_d);
      byp2  = wb_we && (wb_addr != '0) && (wb_addr == rt_d);
      // A flush kills the ID instruction upstream, so it never needs holding.
      stall = ex_q.valid && ex_q.ctrl[MEMREAD_BIT] && (ex_q.rt != '0) && valid_d &&
              ((ex_q.rt == rs_d) || (ex_q.rt == rt_d)) && !flush_e;
      bubble = flush_e || stall;

      ex_d.rdata1 = byp1 ? wb_data : rdata1_d;
      ex_d.rdata2 = byp2 ? wb_data : rdata2_d;
      ex_d.imm    = imm_d;
      ex_d.shamt  = shamt_d;
      ex_d.rs     = rs_d;
      ex_d.rt     = rt_d;
      ex_d.rd     = rd_d;
      ex_d.pc4    = pc4_d;

      if (bubble) begin
         ex_d.valid = 1'b0;
         ex_d.ctrl  = '0;
         ex_d.op    = '0;
         ex_d.func  = '0;
      end else begin
         ex_d.valid = valid_d;
         ex_d.ctrl  = valid_d ? ctrl_d : '0;
         ex_d.op    = op_d;
         ex_d.func  = func_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign stall_d  = stall;
   assign valid_e  = ex_q.valid;
   assign ctrl_e   = ex_q.ctrl;
   assign op_e     = ex_q.op;
   assign func_e   = ex_q.func;
   assign rdata1_e = ex_q.rdata1;
   assign rdata2_e = ex_q.rdata2;
   assign imm_e    = ex_q.imm;
   assign shamt_e  = ex_q.shamt;
   assign rs_e     = ex_q.rs;
   assign rt_e     = ex_q.rt;
   assign rd_e     = ex_q.rd;
   assign pc4_e    = ex_q.pc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of per-cycle stimulus plus reset corner sequences.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        valid_d = 1'b0;
   logic [8:0]  ctrl_d = '0;
   logic [5:0]  op_d = '0, func_d = '0;
   logic [31:0] rdata1_d = '0, rdata2_d = '0, imm_d = '0, pc4_d = '0, wb_data = '0;
   logic [4:0]  shamt_d = '0, rs_d = '0, rt_d = '0, rd_d = '0, wb_addr = '0;
   logic        wb_we = 1'b0, flush_e = 1'b0;
   logic        stall_d, valid_e;
   logic [8:0]  ctrl_e;
   logic [5:0]  op_e, func_e;
   logic [31:0] rdata1_e, rdata2_e, imm_e, pc4_e;
   logic [4:0]  shamt_e, rs_e, rt_e, rd_e;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ctrl_d(ctrl_d), .op_d(op_d), .func_d(func_d),
      .rdata1_d(rdata1_d), .rdata2_d(rdata2_d), .imm_d(imm_d), .shamt_d(shamt_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .pc4_d(pc4_d),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush_e(flush_e),
      .stall_d(stall_d), .valid_e(valid_e), .ctrl_e(ctrl_e), .op_e(op_e), .func_e(func_e),
      .rdata1_e(rdata1_e), .rdata2_e(rdata2_e), .imm_e(imm_e), .shamt_e(shamt_e),
      .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .pc4_e(pc4_e)
   );

   typedef struct {
      logic        v;
      logic [8:0]  ctrl;
      logic [5:0]  op, func;
      logic [4:0]  rs, rt, rd;
      logic [31:0] r1, r2, imm;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        fl;
      logic        x_stall;
      logic        x_v;
      logic [8:0]  x_ctrl;
      logic [5:0]  x_op, x_func;
      logic [31:0] x_r1, x_r2;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      @(negedge clk);
      valid_d = vecs[i].v;   ctrl_d = vecs[i].ctrl; op_d = vecs[i].op; func_d = vecs[i].func;
      rs_d = vecs[i].rs;     rt_d = vecs[i].rt;     rd_d = vecs[i].rd;
      rdata1_d = vecs[i].r1; rdata2_d = vecs[i].r2; imm_d = vecs[i].imm;
      shamt_d = 5'(i);       pc4_d = 32'h0040_0000 + 32'(i) * 4;
      wb_we = vecs[i].we;    wb_addr = vecs[i].wa;  wb_data = vecs[i].wd; flush_e = vecs[i].fl;
      #2;
      check($sformatf("v%0d stall_d", i), 32'(stall_d), 32'(vecs[i].x_stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid_e", i),  32'(valid_e), 32'(vecs[i].x_v));
      check($sformatf("v%0d ctrl_e", i),   32'(ctrl_e),  32'(vecs[i].x_ctrl));
      check($sformatf("v%0d op_e", i),     32'(op_e),    32'(vecs[i].x_op));
      check($sformatf("v%0d func_e", i),   32'(func_e),  32'(vecs[i].x_func));
      check($sformatf("v%0d rdata1_e", i), rdata1_e,     vecs[i].x_r1);
      check($sformatf("v%0d rdata2_e", i), rdata2_e,     vecs[i].x_r2);
      check($sformatf("v%0d imm_e", i),    imm_e,        vecs[i].imm);
      check($sformatf("v%0d rt_e", i),     32'(rt_e),    32'(vecs[i].rt));
      check($sformatf("v%0d rs_e", i),     32'(rs_e),    32'(vecs[i].rs));
      check($sformatf("v%0d rd_e", i),     32'(rd_e),    32'(vecs[i].rd));
      check($sformatf("v%0d shamt_e", i),  32'(shamt_e), i);
      check($sformatf("v%0d pc4_e", i),    pc4_e,        32'h0040_0000 + 32'(i) * 4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, run=%0d failed=%0d", tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

   initial begin
      //        v  ctrl    op     func   rs  rt  rd  r1            r2            imm    we  wa  wd            fl  xs  xv  xctrl   xop    xfunc  xr1           xr2
      vecs[0]  = '{1, 9'h104, 6'h08, 6'h00, 9,  8,  0,  32'h10,       32'h20,       32'd5, 0,  0,  32'h0,        0,  0,  1,  9'h104, 6'h08, 6'h00, 32'h10,       32'h20};
      vecs[1]  = '{1, 9'h1A4, 6'h23, 6'h00, 9,  8,  0,  32'h100,      32'h0,        32'd0, 0,  0,  32'h0,        0,  0,  1,  9'h1A4, 6'h23, 6'h00, 32'h100,      32'h0};
      vecs[2]  = '{1, 9'h102, 6'h00, 6'h20, 8,  11, 10, 32'h1,        32'h2,        32'd0, 0,  0,  32'h0,        0,  1,  0,  9'h000, 6'h00, 6'h00, 32'h1,        32'h2};
      vecs[3]  = '{1, 9'h102, 6'h00, 6'h20, 8,  11, 10, 32'h1,        32'h2,        32'd0, 0,  0,  32'h0,        0,  0,  1,  9'h102, 6'h00, 6'h20, 32'h1,        32'h2};
      vecs[4]  = '{1, 9'h1A4, 6'h23, 6'h00, 9,  0,  0,  32'h200,      32'h0,        32'd4, 0,  0,  32'h0,        0,  0,  1,  9'h1A4, 6'h23, 6'h00, 32'h200,      32'h0};
      vecs[5]  = '{1, 9'h102, 6'h00, 6'h20, 0,  0,  12, 32'h0,        32'h0,        32'd0, 0,  0,  32'h0,        0,  0,  1,  9'h102, 6'h00, 6'h20, 32'h0,        32'h0};
      vecs[6]  = '{1, 9'h104, 6'h08, 6'h00, 9,  8,  0,  32'h0,        32'h55,       32'd0, 1,  9,  32'hDEADBEEF, 0,  0,  1,  9'h104, 6'h08, 6'h00, 32'hDEADBEEF, 32'h55};
      vecs[7]  = '{1, 9'h104, 6'h08, 6'h00, 0,  0,  0,  32'h77,       32'h66,       32'd0, 1,  0,  32'hDEADBEEF, 0,  0,  1,  9'h104, 6'h08, 6'h00, 32'h77,       32'h66};
      vecs[8]  = '{1, 9'h104, 6'h08, 6'h00, 3,  8,  0,  32'h11,       32'h22,       32'd0, 1,  8,  32'hCAFEF00D, 0,  0,  1,  9'h104, 6'h08, 6'h00, 32'h11,       32'hCAFEF00D};
      vecs[9]  = '{1, 9'h1A4, 6'h23, 6'h00, 3,  8,  0,  32'h11,       32'h22,       32'd0, 0,  8,  32'hCAFEF00D, 0,  0,  1,  9'h1A4, 6'h23, 6'h00, 32'h11,       32'h22};
      vecs[10] = '{1, 9'h102, 6'h00, 6'h20, 8,  11, 10, 32'h1,        32'h2,        32'd0, 0,  0,  32'h0,        1,  0,  0,  9'h000, 6'h00, 6'h00, 32'h1,        32'h2};
      vecs[11] = '{0, 9'h102, 6'h0F, 6'h20, 8,  8,  10, 32'h3,        32'h4,        32'd0, 0,  0,  32'h0,        0,  0,  0,  9'h000, 6'h0F, 6'h20, 32'h3,        32'h4};
      vecs[12] = '{1, 9'h1A4, 6'h23, 6'h00, 9,  8,  0,  32'h5,        32'h6,        32'd0, 0,  0,  32'h0,        0,  0,  1,  9'h1A4, 6'h23, 6'h00, 32'h5,        32'h6};
      vecs[13] = '{1, 9'h104, 6'h08, 6'h00, 1,  8,  0,  32'h7,        32'h8,        32'd9, 0,  0,  32'h0,        0,  1,  0,  9'h000, 6'h00, 6'h00, 32'h7,        32'h8};
      vecs[14] = '{1, 9'h1A4, 6'h23, 6'h00, 9,  8,  0,  32'h5,        32'h6,        32'd0, 0,  0,  32'h0,        0,  0,  1,  9'h1A4, 6'h23, 6'h00, 32'h5,        32'h6};
      vecs[15] = '{0, 9'h102, 6'h00, 6'h20, 8,  8,  10, 32'h3,        32'h4,        32'd0, 0,  0,  32'h0,        0,  0,  0,  9'h000, 6'h00, 6'h20, 32'h3,        32'h4};

      // Mid-cycle reset with live inputs: outputs clear before any edge.
      valid_d = 1'b1; ctrl_d = 9'h1A4; op_d = 6'h23; rdata1_d = 32'h1234; pc4_d = 32'h40;
      #1 rst_n = 1'b0;
      #2;
      check("reset valid_e",  32'(valid_e), 0);
      check("reset ctrl_e",   32'(ctrl_e),  0);
      check("reset op_e",     32'(op_e),    0);
      check("reset rdata1_e", rdata1_e,     0);
      check("reset pc4_e",    pc4_e,        0);
      check("reset stall_d",  32'(stall_d), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Reset asserted while a load-use stall is active.
      @(negedge clk);
      valid_d = 1'b1; ctrl_d = 9'h1A4; op_d = 6'h23; func_d = 6'h00;
      rs_d = 5'd9; rt_d = 5'd8; rd_d = 5'd0; flush_e = 1'b0; wb_we = 1'b0;
      rdata1_d = 32'hAA; pc4_d = 32'h80;
      @(posedge clk);
      @(negedge clk);
      ctrl_d = 9'h102; op_d = 6'h00; func_d = 6'h20; rs_d = 5'd8; rt_d = 5'd11; rd_d = 5'd10;
      #2;
      check("pre-reset stall_d", 32'(stall_d), 1);
      rst_n = 1'b0;
      #1;
      check("stall reset stall_d", 32'(stall_d), 0);
      check("stall reset valid_e", 32'(valid_e), 0);
      check("stall reset ctrl_e",  32'(ctrl_e),  0);
      check("stall reset rt_e",    32'(rt_e),    0);
      @(posedge clk);
      #1;
      check("held reset valid_e", 32'(valid_e), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("post-reset stall_d", 32'(stall_d), 0);
      @(posedge clk);
      #1;
      check("post-reset valid_e", 32'(valid_e), 1);
      check("post-reset ctrl_e",  32'(ctrl_e),  32'h102);
      check("post-reset func_e",  32'(func_e),  32'h20);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
